// File: rtl/iZero_pkg.sv
// rtl/iZero_pkg.sv - shared iZero datapath constants and access-size codes
package iZero_pkg;

    localparam int LARGURA_PALAVRA = 32;

    typedef enum logic [1:0] {
        TAM_BYTE    = 2'b00,
        TAM_MEIA    = 2'b01,
        TAM_PALAVRA = 2'b10,
        TAM_ILEGAL  = 2'b11
    } tamanho_t;

endpackage

// File: rtl/alinhador_de_carga.sv
// rtl/alinhador_de_carga.sv - lane select and sign/zero extension of a loaded word
module alinhador_de_carga
    import iZero_pkg::*;
(
    input  logic [LARGURA_PALAVRA-1:0] palavra_i,
    input  logic [1:0]                 offset_i,
    input  logic [1:0]                 tam_i,
    input  logic                       sem_sinal_i,
    output logic [LARGURA_PALAVRA-1:0] dado_o
);

    logic [LARGURA_PALAVRA-1:0] deslocada;

    assign deslocada = palavra_i >> {offset_i, 3'b000};

    always_comb begin
        dado_o = palavra_i;
        case (tam_i)
            TAM_BYTE:
                dado_o = sem_sinal_i ? {24'h0, deslocada[7:0]}
                                     : {{24{deslocada[7]}}, deslocada[7:0]};
            TAM_MEIA:
                dado_o = sem_sinal_i ? {16'h0, deslocada[15:0]}
                                     : {{16{deslocada[15]}}, deslocada[15:0]};
            default: dado_o = palavra_i;
        endcase
    end

endmodule

// File: rtl/memoria_de_dados_parametrizada.sv
// rtl/memoria_de_dados_parametrizada.sv - byte-addressed data memory with sized loads/stores
module memoria_de_dados_parametrizada
    import iZero_pkg::*;
#(
    parameter int                    DEPTH      = 500,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req,
    input  logic                       we,
    input  logic [1:0]                 size,
    input  logic                       unsigned_ld,
    input  logic [ADDR_WIDTH-1:0]      addr,
    input  logic [LARGURA_PALAVRA-1:0] datain,
    output logic [LARGURA_PALAVRA-1:0] dataout,
    output logic                       valid,
    output logic                       erro
);

    localparam int                    IDXW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

    logic [3:0][7:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0]      rel, idx_full;
    logic [IDXW-1:0]            idx;
    logic [1:0]                 offset;
    logic                       desalinhado, rejeita, aceita;
    logic [3:0]                 be;
    logic [3:0][7:0]            wdata;
    logic [LARGURA_PALAVRA-1:0] palavra_lida, carga;

    logic [LARGURA_PALAVRA-1:0] dataout_q, dataout_d;
    logic                       valid_q, valid_d, erro_q, erro_d;

    // BASE_ADDR is 4-aligned, so the low bits of rel equal addr[1:0]
    assign rel      = addr - BASE_ADDR;
    assign offset   = rel[1:0];
    assign idx_full = {2'b00, rel[ADDR_WIDTH-1:2]};
    assign idx      = idx_full[IDXW-1:0];

    always_comb begin
        desalinhado = 1'b0;
        be          = 4'b0000;
        wdata       = datain;
        case (size)
            TAM_BYTE: begin
                be    = 4'b0001 << offset;
                wdata = {4{datain[7:0]}};
            end
            TAM_MEIA: begin
                desalinhado = offset[0];
                be          = 4'b0011 << offset;
                wdata       = {2{datain[15:0]}};
            end
            TAM_PALAVRA: begin
                desalinhado = (offset != 2'b00);
                be          = 4'b1111;
            end
            default: desalinhado = 1'b1;
        endcase
        rejeita = desalinhado | (addr < BASE_ADDR) | (idx_full >= DEPTH_A);
        aceita  = req & ~rejeita;
    end

    // Storage has no reset; gating on rst_n keeps a store during reset from landing
    always_ff @(posedge clk) begin
        if (aceita && we && rst_n) begin
            for (int l = 0; l < 4; l++) begin
                if (be[l]) mem_q[idx][l] <= wdata[l];
            end
        end
    end

    assign palavra_lida = mem_q[idx];

    alinhador_de_carga u_alinhador (
        .palavra_i   (palavra_lida),
        .offset_i    (offset),
        .tam_i       (size),
        .sem_sinal_i (unsigned_ld),
        .dado_o      (carga)
    );

    always_comb begin
        dataout_d = dataout_q;
        valid_d   = 1'b0;
        erro_d    = 1'b0;
        if (req) begin
            if (rejeita) begin
                erro_d = 1'b1;
            end else if (!we) begin
                valid_d   = 1'b1;
                dataout_d = carga;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dataout_q <= '0;
            valid_q   <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            dataout_q <= dataout_d;
            valid_q   <= valid_d;
            erro_q    <= erro_d;
        end
    end

    assign dataout = dataout_q;
    assign valid   = valid_q;
    assign erro    = erro_q;

endmodule

// File: doc/memoria_de_dados_parametrizada.md
# memoria_de_dados_parametrizada

Parametrised single-port data memory for the iZero datapath; it succeeds the fixed 32-bit word-addressed data RAM. It adds byte addressing, byte/halfword/word loads and stores with sign or zero extension, and an explicit request/valid handshake. It also flags misaligned and out-of-range accesses. It sits between the ALU address output and the write-back mux, on the CPU core clock only.

## Interface
Parameters:
- DEPTH, 500: number of 32-bit words stored.
- ADDR_WIDTH, 32: width of the byte address.
- BASE_ADDR, 0: byte address mapped to word 0. Must be 4-aligned.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  1  access request, sampled on the rising edge of clk.
- we  in  1  1 = store, 0 = load; meaningful only when req=1.
- size  in  2  access size: 00 byte, 01 halfword, 10 word; 11 is illegal.
- unsigned_ld  in  1  1 = zero-extend a sub-word load, 0 = sign-extend.
- addr  in  ADDR_WIDTH  byte address.
- datain  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- dataout  out  32  load result, extended to 32 bits.
- valid  out  1  one-cycle pulse: dataout holds a new load result.
- erro  out  1  one-cycle pulse: the previous request was rejected.

## Operation
- Word index = (addr − BASE_ADDR) >> 2; offset = addr[1:0].
- A request is rejected when any of these hold:
  - size = 11;
  - halfword with offset[0] = 1;
  - word with offset ≠ 0;
  - addr < BASE_ADDR;
  - word index ≥ DEPTH.
- A rejected request leaves memory unwritten, pulses erro, keeps valid=0 and holds dataout.
- Store (req=1, we=1, accepted): writes only the addressed lanes.
  - byte: lane = offset, data = datain[7:0].
  - halfword: lanes offset and offset+1, data = datain[15:0], little-endian.
  - word: all four lanes.
  - Other bytes of the word are unchanged. No valid pulse; dataout holds.
- Load (req=1, we=0, accepted): reads the addressed lane(s), shifts them down to bit 0, then extends per unsigned_ld. Word loads ignore unsigned_ld.
- req=0: no memory activity; valid=0, erro=0; dataout holds.
- Memory contents are not initialised and not cleared by reset.

## Timing
- Load latency is 1 cycle: a request on edge N gives dataout and valid=1 after edge N, readable at edge N+1.
- erro follows the same 1-cycle timing.
- Store takes effect at edge N. A load at edge N+1 to the same word returns the new bytes.
- One request per cycle. Back-to-back requests are accepted every cycle, with no stall and no ready signal.
- valid and erro are never both 1.
- Reset values: dataout=0, valid=0, erro=0.
- Asserting rst_n=0 clears the outputs immediately, without waiting for clk.
- A request sampled on the same edge that rst_n deasserts is ignored. The first accepted request is at the first edge with rst_n=1 already stable.
- A store in flight when reset asserts must not corrupt any word other than the addressed one. Whether the addressed word is written is undefined.

## Structure
- Shared package iZero_pkg holds:
  - size codes TAM_BYTE=2'b00, TAM_MEIA=2'b01, TAM_PALAVRA=2'b10;
  - the 32-bit word width constant.
- Storage is a 4-lane byte-enabled array of DEPTH words, to map onto block RAM with byte enables.
- Sub-module alinhador_de_carga (combinational) performs lane select plus sign/zero extension. It is reused later by the cache.
- The top module holds the address decode, error checks, store lane-enable generation and output registers.

## Test plan
- Word store then load: store 0xDEADBEEF at addr 0x10, then load word at 0x10 → next cycle dataout=0xDEADBEEF, valid=1.
- Byte lanes and extension, after the word store above:
  - store byte 0x80 at 0x11;
  - signed byte load at 0x11 → dataout=0xFFFFFF80;
  - unsigned byte load at 0x11 → 0x00000080;
  - word load at 0x10 → 0xDEAD80EF.
- Halfword access:
  - store halfword 0x8001 at 0x22;
  - signed halfword load at 0x22 → 0xFFFF8001; unsigned → 0x00008001;
  - word load at 0x20 → 0x8001xxxx, with the lower half unchanged.
- Errors, each in turn:
  - halfword at 0x13, word at 0x12, size=11, addr = BASE_ADDR + 4·DEPTH;
  - each → erro=1 for one cycle, valid=0, and a following load shows the memory unchanged.
- Back-to-back and read-after-write:
  - alternate store/load to 0x30 every cycle for 8 cycles with incrementing data;
  - each load returns the value stored one cycle earlier; valid pulses only on the load cycles.
- Reset:
  - drive rst_n=0 mid-way between edges while valid=1 → dataout=0 and valid=0 immediately;
  - after release, a word load of a previously stored address returns its pre-reset contents.
